// File: rtl/sub_bytes_seq.sv
// Purpose : AES SubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per clock via a shared S-box function.
// Latency : NUM_CHUNKS (=16/BYTES_PER_CYCLE) cycles from accept edge to out_valid; back-to-back accept on consume.
// Backpressure: result held stable in DONE while out_ready=0; in_ready=0 until the result is consumed.
//
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_state (input handshake),
//        out_valid/out_ready/so (result handshake, so feeds shift_rows.si).
// Optional: define SUB_BYTES_INV_EN to add port dec (1 = inverse S-box, sampled at accept).
module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef SUB_BYTES_INV_EN
    input  logic         dec,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] so
);

    localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

`ifdef SUB_BYTES_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

    // Single lookup point so every chunk goes through the same table mux.
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? sbox_inv(b) : sbox_fwd(b);
    endfunction
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic [127:0]       so_q, so_d;
    logic               out_valid_q, out_valid_d;
`ifdef SUB_BYTES_INV_EN
    logic               dec_q, dec_d;
`endif

    // Only DONE looks at out_ready, so a consume and a new accept share one edge.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign so        = so_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        so_d        = so_q;
        out_valid_d = out_valid_q;
`ifdef SUB_BYTES_INV_EN
        dec_d       = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef SUB_BYTES_INV_EN
                    dec_d   = dec;
`endif
                end
            end
            BUSY: begin
                // Chunk k covers bytes k*B .. k*B+B-1; byte i lives at bits [127-8i -: 8].
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
`ifdef SUB_BYTES_INV_EN
                    work_d[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + j) -: 8] =
                        sub_byte(work_q[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + j) -: 8], dec_q);
`else
                    work_d[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + j) -: 8] =
                        sbox_fwd(work_q[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + j) -: 8]);
`endif
                end
                if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
                    // Result register is loaded only here, so it never shows a partial state.
                    cnt_d       = '0;
                    so_d        = work_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        work_d  = in_state;
                        cnt_d   = '0;
                        state_d = BUSY;
`ifdef SUB_BYTES_INV_EN
                        dec_d   = dec;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            so_q        <= '0;
            out_valid_q <= 1'b0;
`ifdef SUB_BYTES_INV_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            so_q        <= so_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_BYTES_INV_EN
            dec_q       <= dec_d;
`endif
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: default build (forward only), B=4 main instance plus B=1/2/8/16 sweep instances.
// Reference S-box is derived from GF(2^8) inversion and the AES affine map.
// Ends with one TB_RESULT summary line.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] so;

    logic         sw_in_valid  = 1'b0;
    logic         sw_out_ready = 1'b1;
    logic [127:0] sw_in_state  = '0;
    logic [3:0]   sw_in_ready;
    logic [3:0]   sw_out_valid;
    logic [127:0] sw_so [4];

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_ref [256];

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam int MAIN_LAT = 4;

    always #5 clk = ~clk;

    sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .so(so)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]), .in_state(sw_in_state),
            .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready), .so(sw_so[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_ref[st[127 - 8*i -: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] garbage();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one state, wait for its result, check latency/value, then hold it for `hold` cycles.
    // Leaves the DUT in DONE with out_ready=0 so the next call exercises the back-to-back path.
    task automatic run_one(input logic [127:0] st, input logic [127:0] exp, input int hold, input string name);
        int lat;
        logic [127:0] held;
        in_state  = st;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_state  = garbage();
        out_ready = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            in_state = garbage();
        end
        out_ready = 1'b0;
        check({name, "_latency"}, 128'(lat), 128'(MAIN_LAT));
        check({name, "_so"}, so, exp);
        held = exp;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = garbage();
            #1;
            check({name, "_hold_in_ready"}, 128'(in_ready), 128'(1'b0));
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 128'(out_valid), 128'(1'b1));
            check({name, "_hold_so"}, so, held);
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [127:0] st;
        logic [127:0] exp;
        int           hold;
        string        name;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   first [4];
        int   exp_lat [4];
        logic [127:0] st;

        vecs[0] = '{APPB_IN, APPB_OUT, 0, "appB"};
        vecs[1] = '{{16{8'h00}}, {16{8'h63}}, 2, "zeros"};
        vecs[2] = '{{16{8'hff}}, {16{8'h16}}, 0, "ones"};
        vecs[3] = '{{16{8'h53}}, {16{8'hed}}, 10, "backpressure"};
        vecs[4] = '{APPB_IN, APPB_OUT, 1, "after_bp"};
        exp_lat = '{16, 8, 2, 1};

        for (int a = 0; a < 256; a++) begin
            logic [7:0] v;
            v = ginv(8'(a));
            sbox_ref[a] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        #12;
        check("reset_out_valid", 128'(out_valid), 128'(1'b0));
        check("reset_so", so, '0);
        check("reset_in_ready", 128'(in_ready), 128'(1'b1));
        check("reset_sweep_valid", 128'(sw_out_valid), 128'(4'h0));
        @(negedge clk) rst_n = 1'b1;

        // First accept lands on the first rising edge after release.
        for (int i = 0; i < 5; i++) run_one(vecs[i].st, vecs[i].exp, vecs[i].hold, vecs[i].name);

        for (int n = 0; n < 30; n++) begin
            st = garbage();
            run_one(st, ref_sub(st), $urandom_range(0, 3), "rand");
        end

        // Consume without a new input: back to IDLE, result retained.
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_valid", 128'(out_valid), 128'(1'b0));
        check("drain_so_kept", so, ref_sub(st));
        out_ready = 1'b0;
        #1;
        check("drain_in_ready", 128'(in_ready), 128'(1'b1));

        // Reset while chunk 1 is pending.
        in_state = APPB_IN; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy_valid", 128'(out_valid), 128'(1'b0));
        check("rst_busy_so", so, '0);
        check("rst_busy_in_ready", 128'(in_ready), 128'(1'b1));
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 128'(out_valid), 128'(1'b0));
            check("post_rst_so", so, '0);
        end
        run_one(APPB_IN, APPB_OUT, 0, "post_rst");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Parameter sweep.
        check("sweep_in_ready", 128'(sw_in_ready), 128'(4'hf));
        sw_in_state = APPB_IN; sw_in_valid = 1'b1; sw_out_ready = 1'b1;
        for (int g = 0; g < 4; g++) first[g] = -1;
        @(posedge clk); #1;
        sw_in_valid = 1'b0;
        sw_in_state = garbage();
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++) begin
                if (first[g] < 0 && sw_out_valid[g]) begin
                    first[g] = c;
                    check($sformatf("sweep%0d_so", g), sw_so[g], APPB_OUT);
                end
            end
        end
        for (int g = 0; g < 4; g++)
            check($sformatf("sweep%0d_latency", g), 128'(first[g]), 128'(exp_lat[g]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
